edge_event_scheduler: RTL and testbench
=======================================

EDGE_EVENT_SCHEDULER -- requirements
Module: edge_event_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of monitored input signals (2..32).
REQ-002 SHALL have parameter INDEX_WIDTH, default $clog2(CHANNELS), width of event_index.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port signals  input  CHANNELS  level inputs, already synchronous to clock.
REQ-006 SHALL have port event_valid  output  1  an event is presented.
REQ-007 SHALL have port event_ready  input  1  consumer accepts the presented event.
REQ-008 SHALL have port event_index  output  INDEX_WIDTH  channel number of the presented event.
REQ-009 SHALL have port pending  output  CHANNELS  per-channel captured, not-yet-presented event flags.
REQ-010 SHALL have port overflow  output  CHANNELS  sticky per-channel lost-event flags.
REQ-011 SHALL have port overflow_clear  input  1  single-cycle pulse clearing all overflow bits.

Function
REQ-012 SHALL detect a rising edge on channel i when signals[i]=1 and its previously sampled value was 0.
REQ-013 SHALL set pending[i] on the clock edge at which the rising edge of channel i is detected.
REQ-014 SHALL hold a one-entry output register (event_valid, event_index), loaded when event_valid=0 or event_valid&event_ready.
REQ-015 SHALL, on load with pending!=0, select one channel by round-robin, starting at last_grant+1 and wrapping at CHANNELS-1 to 0.
REQ-016 SHALL, on load, clear the selected pending bit, update last_grant to it, and set event_valid=1; with pending=0, event_valid goes 0.
REQ-017 SHALL have latency of exactly 2 clock edges, detection to event_valid, when the output register is free.
REQ-018 SHALL keep event_valid and event_index stable while event_valid=1 and event_ready=0.
REQ-019 SHALL sustain one accepted event per cycle when event_ready is held high and pending!=0.
REQ-020 SHALL, for a rising edge on channel i in the cycle its pending bit is moved to the output, leave pending[i]=1.
REQ-021 SHALL, for a rising edge on channel i with pending[i]=1 and not being cleared that cycle, drop the event and set overflow[i].
REQ-022 SHALL keep overflow bits set until overflow_clear; an overflow set in the same cycle as the clear wins.
REQ-023 SHALL ignore event_ready while event_valid=0.

Reset
REQ-024 SHALL, on resetn low, immediately clear event_valid, event_index, pending, overflow and all sampled-previous values to 0.
REQ-025 SHALL reset last_grant to CHANNELS-1 so channel 0 wins first arbitration.
REQ-026 SHALL treat a signal already high at reset release as a rising edge on the first clock edge.
REQ-027 SHALL discard an in-flight presented event on reset mid-handshake, with no replay.

Structure
REQ-028 SHALL instantiate one rising_edge_detector sub-module per channel via a generate loop.
REQ-029 SHALL implement the round-robin selection as a local combinational function or block, not a separate module.
REQ-030 SHALL use no shared package; INDEX_WIDTH is the only derived constant.

Verification (CHANNELS=4)
REQ-031 SHALL cover a single edge: signals[2] rises at edge E -> pending[2]=1 after E, event_valid=1 with index 2 after E+1; ready=1 clears it at E+2.
REQ-032 SHALL cover simultaneous edges: signals=4'b1111 rises together, ready held 1 -> indices 0,1,2,3 on consecutive cycles, then event_valid=0.
REQ-033 SHALL cover backpressure: ready=0 for 5 cycles with channel 1 presented while channel 0 rises -> index stays 1; after ready, index 0 next.
REQ-034 SHALL cover overflow: channel 3 pulses twice while pending[3]=1 and ready=0 -> overflow=4'b1000; one event only for channel 3; overflow_clear -> 0.
REQ-035 SHALL cover fairness: channels 0 and 1 re-pulse continuously, ready=1 -> grants alternate 0,1,0,1 with no starvation.
REQ-036 SHALL cover reset mid-operation: resetn low while event_valid=1 and pending=4'b0110 -> all outputs 0 asynchronously; a channel held high restarts with an event after release.

Source files
------------

// File: rtl/rising_edge_detector.sv
// ----------------------------------------------------------------------------
// rising_edge_detector
//   Flags a 0->1 transition on a level input that is already synchronous to
//   clock. The previous sample resets to 0, so an input that is already high
//   when reset is released reports a rising edge on the first clock edge.
//
// Ports
//   clock    in   single clock, rising edge
//   resetn   in   asynchronous active-low reset
//   level_i  in   level input
//   rise_o   out  combinational rising-edge flag for the current cycle
// ----------------------------------------------------------------------------
module rising_edge_detector (
    input  logic clock,
    input  logic resetn,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level_i;
        rise_o = level_i & ~prev_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/edge_event_scheduler.sv
// ----------------------------------------------------------------------------
// edge_event_scheduler
//   Watches CHANNELS level inputs for rising edges, latches each edge into a
//   per-channel pending flag and presents pending channels one at a time on a
//   valid/ready output register, chosen round-robin after the last grant. An
//   edge on a channel whose previous event is still pending is dropped and
//   recorded in a sticky overflow flag.
//
// Ports
//   clock           in   single clock, rising edge
//   resetn          in   asynchronous active-low reset
//   signals         in   [CHANNELS]     level inputs, synchronous to clock
//   event_valid     out                 an event is presented
//   event_ready     in                  consumer accepts the presented event
//   event_index     out  [INDEX_WIDTH]  channel of the presented event
//   pending         out  [CHANNELS]     captured, not yet presented events
//   overflow        out  [CHANNELS]     sticky lost-event flags
//   overflow_clear  in                  pulse clearing all overflow flags
// ----------------------------------------------------------------------------
module edge_event_scheduler #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned INDEX_WIDTH = $clog2(CHANNELS)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [CHANNELS-1:0]    signals,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [INDEX_WIDTH-1:0] event_index,
    output logic [CHANNELS-1:0]    pending,
    output logic [CHANNELS-1:0]    overflow,
    input  logic                   overflow_clear
);

    logic [CHANNELS-1:0]    rise;

    logic                   valid_q,      valid_d;
    logic [INDEX_WIDTH-1:0] index_q,      index_d;
    logic [INDEX_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [CHANNELS-1:0]    pending_q,    pending_d;
    logic [CHANNELS-1:0]    overflow_q,   overflow_d;

    logic                   load;
    logic                   grant_found;
    logic [INDEX_WIDTH-1:0] grant_idx;
    logic [CHANNELS-1:0]    clear_mask;
    logic [CHANNELS-1:0]    shifted;
    int unsigned            cand;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_det
        rising_edge_detector u_det (
            .clock   (clock),
            .resetn  (resetn),
            .level_i (signals[g]),
            .rise_o  (rise[g])
        );
    end

    // Round-robin pick: scan from last_grant+1 upward, wrapping, and take the
    // first pending channel. The last candidate checked is last_grant itself.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        shifted     = '0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            cand    = (32'(last_grant_q) + k) % CHANNELS;
            shifted = pending_q >> cand;
            if (!grant_found && shifted[0]) begin
                grant_found = 1'b1;
                grant_idx   = INDEX_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        valid_d      = valid_q;
        index_d      = index_q;
        last_grant_d = last_grant_q;
        clear_mask   = '0;
        load         = ~valid_q | event_ready;

        if (load) begin
            if (grant_found) begin
                valid_d      = 1'b1;
                index_d      = grant_idx;
                last_grant_d = grant_idx;
                clear_mask   = {{(CHANNELS-1){1'b0}}, 1'b1} << grant_idx;
            end else begin
                valid_d = 1'b0;
            end
        end

        // A fresh edge on a bit being moved out re-arms it; an edge on a bit
        // that stays pending is lost and flagged.
        pending_d  = (pending_q & ~clear_mask) | rise;
        overflow_d = (overflow_clear ? '0 : overflow_q) | (rise & pending_q & ~clear_mask);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q      <= 1'b0;
            index_q      <= '0;
            last_grant_q <= INDEX_WIDTH'(CHANNELS - 1);
            pending_q    <= '0;
            overflow_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            index_q      <= index_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
        end
    end

    assign event_valid = valid_q;
    assign event_index = index_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// ----------------------------------------------------------------------------
// tb_edge_event_scheduler
//   Directed bench for edge_event_scheduler with CHANNELS=4. Inputs change
//   and outputs are sampled 1 time unit after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_edge_event_scheduler;

    localparam int unsigned CHANNELS    = 4;
    localparam int unsigned INDEX_WIDTH = 2;

    logic                   clock;
    logic                   resetn;
    logic [CHANNELS-1:0]    signals;
    logic                   event_valid;
    logic                   event_ready;
    logic [INDEX_WIDTH-1:0] event_index;
    logic [CHANNELS-1:0]    pending;
    logic [CHANNELS-1:0]    overflow;
    logic                   overflow_clear;

    int n_cmp = 0;
    int n_err = 0;

    edge_event_scheduler #(
        .CHANNELS    (CHANNELS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .signals        (signals),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_index    (event_index),
        .pending        (pending),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn         = 1'b1;
        signals        = '0;
        event_ready    = 1'b0;
        overflow_clear = 1'b0;
        #1 resetn = 1'b0;
        #2;
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_index", 32'(event_index), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        #5 resetn = 1'b1;
        step();

        // Simultaneous edges, ready held high: 0,1,2,3 then idle.
        signals     = 4'b1111;
        event_ready = 1'b1;
        step();
        check("sim_pend", 32'(pending), 32'hf);
        check("sim_valid0", 32'(event_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("sim_valid", 32'(event_valid), 32'd1);
            check("sim_index", 32'(event_index), 32'(k));
        end
        check("sim_pend_empty", 32'(pending), 32'd0);
        step();
        check("sim_idle", 32'(event_valid), 32'd0);
        signals     = '0;
        event_ready = 1'b0;
        step();

        // Single edge on channel 2.
        signals = 4'b0100;
        step();
        check("single_pend", 32'(pending), 32'h4);
        check("single_valid_early", 32'(event_valid), 32'd0);
        step();
        check("single_valid", 32'(event_valid), 32'd1);
        check("single_index", 32'(event_index), 32'd2);
        check("single_pend_moved", 32'(pending), 32'd0);
        event_ready = 1'b1;
        step();
        check("single_done", 32'(event_valid), 32'd0);
        signals     = '0;
        event_ready = 1'b0;
        step();

        // Backpressure: channel 1 held presented while channel 0 rises.
        signals = 4'b0010;
        step();
        step();
        check("bp_index1", 32'(event_index), 32'd1);
        signals = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_valid", 32'(event_valid), 32'd1);
            check("bp_hold_index", 32'(event_index), 32'd1);
        end
        check("bp_pend", 32'(pending), 32'h1);
        event_ready = 1'b1;
        step();
        check("bp_next_valid", 32'(event_valid), 32'd1);
        check("bp_next_index", 32'(event_index), 32'd0);
        step();
        check("bp_drained", 32'(event_valid), 32'd0);
        signals     = '0;
        event_ready = 1'b0;
        step();

        // Overflow: channel 3 pulses twice more while still pending.
        signals = 4'b0100;
        step();
        step();
        check("ov_hold_index", 32'(event_index), 32'd2);
        signals = 4'b1100;
        step();
        check("ov_pend", 32'(pending), 32'h8);
        check("ov_none_yet", 32'(overflow), 32'd0);
        for (int k = 0; k < 2; k++) begin
            signals = 4'b0100;
            step();
            signals = 4'b1100;
            step();
            check("ov_set", 32'(overflow), 32'h8);
        end
        signals     = 4'b0100;
        event_ready = 1'b1;
        step();
        check("ov_ch3_valid", 32'(event_valid), 32'd1);
        check("ov_ch3_index", 32'(event_index), 32'd3);
        step();
        check("ov_one_event", 32'(event_valid), 32'd0);
        check("ov_pend_empty", 32'(pending), 32'd0);
        event_ready = 1'b0;
        check("ov_sticky", 32'(overflow), 32'h8);
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        check("ov_cleared", 32'(overflow), 32'd0);
        signals = '0;
        step();

        // Fairness: channels 0 and 1 re-pulse every other cycle.
        event_ready = 1'b1;
        signals     = 4'b0011;
        step();
        for (int k = 0; k < 6; k++) begin
            signals = (k % 2 == 0) ? 4'b0000 : 4'b0011;
            step();
            check("fair_valid", 32'(event_valid), 32'd1);
            check("fair_index", 32'(k % 2), 32'(event_index));
        end
        check("fair_no_ovf", 32'(overflow), 32'd0);
        signals = '0;
        step();
        step();
        step();
        check("fair_drained", 32'(event_valid), 32'd0);
        event_ready = 1'b0;

        // Reset mid-operation with channel 3 presented and 1,2 pending.
        signals = 4'b1000;
        step();
        step();
        signals = 4'b1110;
        step();
        check("rmid_valid", 32'(event_valid), 32'd1);
        check("rmid_index", 32'(event_index), 32'd3);
        check("rmid_pend", 32'(pending), 32'h6);
        #2 resetn = 1'b0;
        #1;
        check("rmid_async_valid", 32'(event_valid), 32'd0);
        check("rmid_async_index", 32'(event_index), 32'd0);
        check("rmid_async_pend", 32'(pending), 32'd0);
        check("rmid_async_ovf", 32'(overflow), 32'd0);
        #2 resetn = 1'b1;
        step();
        check("rmid_no_replay", 32'(event_valid), 32'd0);
        check("rmid_repend", 32'(pending), 32'he);
        step();
        check("rmid_restart_valid", 32'(event_valid), 32'd1);
        check("rmid_restart_index", 32'(event_index), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
